// File: rtl/trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : trace_buffer
// Brief    : Circular capture buffer for packed N-wide vectors with a
//            valid/ready element-serial drain port. Optional build macro
//            TRACE_BUFFER_TIMESTAMP_EN adds a per-vector cycle timestamp beat.
// Revision : 1.0 - initial release
// ============================================================================
module trace_buffer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int TB_SIZE            = 8,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tracing,
  input  logic                             valid_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic                             drain_req,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [$clog2(TB_SIZE):0]         count,
  output logic                             overflow,
  output logic                             busy
);

  localparam int PW = $clog2(TB_SIZE);
  localparam int CW = PW + 1;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
  localparam int ELEM_OFS = 1;
`else
  localparam int ELEM_OFS = 0;
`endif
  localparam int BEATS = N + ELEM_OFS;
  localparam int EIW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CW-1:0]  c_FULL      = CW'(TB_SIZE);
  localparam logic [CW-1:0]  c_ONE       = CW'(1);
  localparam logic [EIW-1:0] c_LAST_BEAT = EIW'(BEATS - 1);
  localparam logic [7:0]     c_CFG_ID    = 8'(PERSONAL_CONFIG_ID);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [EIW-1:0] elem_idx_q, elem_idx_d;
  logic           overflow_q, overflow_d;
  logic           mode_q, mode_d;
  logic           w_we;

  logic [N-1:0][DATA_WIDTH-1:0] mem_q [TB_SIZE];
  logic [N-1:0][DATA_WIDTH-1:0] w_rd_vec;
  logic [DATA_WIDTH-1:0]        w_elem;
  logic                         w_unused_cfg;

  assign w_unused_cfg = ^configData[7:1];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    elem_idx_d = elem_idx_q;
    overflow_d = overflow_q;
    mode_d     = mode_q;
    w_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tracing && (configId == c_CFG_ID)) begin
          mode_d = configData[0];
        end
        if (tracing) begin
          state_d    = S_TRACE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          elem_idx_d = '0;
        end else if (drain_req && (count_q != '0)) begin
          state_d    = S_DRAIN;
          elem_idx_d = '0;
        end
      end
      S_TRACE: begin
        if (!tracing) begin
          state_d = S_IDLE;
        end else if (valid_in) begin
          if (count_q != c_FULL) begin
            w_we     = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
            // Circular mode sacrifices the oldest vector to keep the newest.
            if (!mode_q) begin
              w_we     = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (elem_idx_q == c_LAST_BEAT) begin
            elem_idx_d = '0;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
            if (count_q == c_ONE) begin
              state_d = S_IDLE;
            end
          end else begin
            elem_idx_d = elem_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      elem_idx_q <= '0;
      overflow_q <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      elem_idx_q <= elem_idx_d;
      overflow_q <= overflow_d;
      mode_q     <= mode_d;
    end
  end

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[wr_ptr_q] <= vector_in;
    end
  end

  assign w_rd_vec = mem_q[rd_ptr_q];

`ifdef TRACE_BUFFER_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem_q [TB_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      ts_mem_q[wr_ptr_q] <= ts_q;
    end
  end

  always_comb begin
    w_elem = DATA_WIDTH'(ts_mem_q[rd_ptr_q]);
    for (int j = 0; j < N; j++) begin
      if (elem_idx_q == EIW'(j + ELEM_OFS)) begin
        w_elem = w_rd_vec[j];
      end
    end
  end
`else
  always_comb begin
    w_elem = '0;
    for (int j = 0; j < N; j++) begin
      if (elem_idx_q == EIW'(j + ELEM_OFS)) begin
        w_elem = w_rd_vec[j];
      end
    end
  end
`endif

  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q == S_DRAIN);
  assign out_data  = (state_q == S_DRAIN) ? w_elem : '0;
  assign out_last  = (state_q == S_DRAIN) && (count_q == c_ONE) &&
                     (elem_idx_q == c_LAST_BEAT);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_buffer
// Brief    : Directed self-checking bench for trace_buffer (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_buffer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TB = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 tracing;
  logic                 valid_in;
  logic [N-1:0][DW-1:0] vector_in;
  logic [7:0]           configId;
  logic [7:0]           configData;
  logic                 drain_req;
  logic                 out_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_last;
  logic [3:0]           count;
  logic                 overflow;
  logic                 busy;

  int n_chk = 0;
  int n_err = 0;

  trace_buffer #(
    .N(N), .DATA_WIDTH(DW), .TB_SIZE(TB), .PERSONAL_CONFIG_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .vector_in(vector_in), .configId(configId), .configData(configData),
    .drain_req(drain_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .count(count),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] id, input logic [7:0] d);
    configId   = id;
    configData = d;
    @(negedge clk);
    configId   = 8'hFF;
    configData = 8'h00;
  endtask

  // Vector k carries element j = 16*k + j.
  task automatic capture(input int nvec);
    tracing  = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    for (int k = 0; k < nvec; k++) begin
      valid_in = 1'b1;
      for (int j = 0; j < N; j++) vector_in[j] = 32'(16 * k + j);
      @(negedge clk);
    end
    valid_in = 1'b0;
    tracing  = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_drain();
    drain_req = 1'b1;
    @(negedge clk);
    drain_req = 1'b0;
  endtask

  // Drains nvec vectors starting at vector first_k; bp selects out_ready 1,0,0,...
  task automatic run_drain(input int first_k, input int nvec, input bit bp);
    int total;
    int i;
    int cyc;
    bit rdy;
    total = nvec * N;
    i     = 0;
    cyc   = 0;
    while (i < total && cyc < 1000) begin
      check("out_valid", 32'(out_valid), 1);
      check("out_data", out_data, 32'(16 * (first_k + i / N) + i % N));
      check("out_last", 32'(out_last), 32'(i == total - 1));
      rdy       = bp ? (cyc % 3 == 0) : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      if (rdy) i++;
      cyc++;
    end
    if (cyc >= 1000) check("drain_timeout", 0, 1);
    out_ready = 1'b0;
    check("valid_after_drain", 32'(out_valid), 0);
    check("busy_after_drain", 32'(busy), 0);
    check("count_after_drain", 32'(count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    tracing    = 1'b0;
    valid_in   = 1'b0;
    vector_in  = '0;
    configId   = 8'hFF;
    configData = 8'h00;
    drain_req  = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // drain request with empty buffer
    start_drain();
    check("empty_drain_valid", 32'(out_valid), 0);
    check("empty_drain_busy", 32'(busy), 0);

    // basic capture and drain
    capture(3);
    check("basic_count", 32'(count), 3);
    check("basic_overflow", 32'(overflow), 0);
    start_drain();
    check("basic_busy", 32'(busy), 1);
    run_drain(0, 3, 1'b0);

    // wrong config id must not change mode; circular overflow
    cfg(8'h05, 8'h01);
    capture(10);
    check("circ_count", 32'(count), 8);
    check("circ_overflow", 32'(overflow), 1);
    start_drain();
    run_drain(2, 8, 1'b0);

    // stop-when-full
    cfg(8'h00, 8'h01);
    capture(10);
    check("stop_count", 32'(count), 8);
    check("stop_overflow", 32'(overflow), 1);
    start_drain();
    run_drain(0, 8, 1'b0);

    // backpressure
    capture(3);
    start_drain();
    run_drain(0, 3, 1'b1);

    // tracing/valid_in ignored during DRAIN
    cfg(8'h00, 8'h00);
    capture(1);
    start_drain();
    out_ready = 1'b0;
    tracing   = 1'b1;
    valid_in  = 1'b1;
    repeat (2) @(negedge clk);
    check("drain_ign_count", 32'(count), 1);
    check("drain_ign_busy", 32'(busy), 1);
    check("drain_ign_data", out_data, 0);
    tracing  = 1'b0;
    valid_in = 1'b0;
    run_drain(0, 1, 1'b0);

    // async reset after the 5th accepted beat
    capture(3);
    start_drain();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_data", out_data, 5);
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 0);
    check("async_busy", 32'(busy), 0);
    check("async_count", 32'(count), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    capture(1);
    check("post_rst_count", 32'(count), 1);
    start_drain();
    run_drain(0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
